// File: rtl/gray_ctrl_pkg.sv
// Shared encodings for the Gray-code sequencing controller: host command
// opcodes and controller states.
package gray_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_RUN    = 2'b00,
        OP_STOP   = 2'b01,
        OP_STEP_N = 2'b10,
        OP_LOAD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_e;

endpackage

// File: rtl/gray_step.sv
// Combinational single-step advance of a reflected-Gray value in either
// direction, with the binary equivalent of the result and a wrap flag.
module gray_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    input  logic             dir,
    output logic [WIDTH-1:0] gray_nxt,
    output logic [WIDTH-1:0] bin_nxt,
    output logic             wrap
);

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] bin_cur;

    always_comb begin
        bin_cur  = gray2bin(gray);
        bin_nxt  = dir ? (bin_cur - WIDTH'(1)) : (bin_cur + WIDTH'(1));
        gray_nxt = bin_nxt ^ (bin_nxt >> 1);
        // Wrap is judged on the value being left, not the one being entered.
        wrap     = dir ? (bin_cur == '0) : (bin_cur == '1);
    end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Command-driven sequencer owning a Gray-code state register: free-run,
// N-step burst, load and stop, with done/wrap/err single-cycle pulses.
module gray_seq_ctrl
    import gray_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             cmd_dir,
    output logic [WIDTH-1:0] gray_q,
    output logic [WIDTH-1:0] bin_q,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] gray_d, bin_d;
    logic             done_d, wrap_d, err_d;
    logic             accept, adv, step_dir;
    logic [WIDTH-1:0] step_gray, step_bin;
    logic             step_wrap;
    op_e              op;

    assign op        = op_e'(cmd_op);
    assign cmd_ready = (state_q != ST_STEP);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    // A RUN re-issued while running counts in its new direction on the same edge.
    assign step_dir  = (state_q == ST_RUN && accept && op == OP_RUN) ? cmd_dir : dir_q;

    gray_step #(.WIDTH(WIDTH)) u_step (
        .gray     (gray_q),
        .dir      (step_dir),
        .gray_nxt (step_gray),
        .bin_nxt  (step_bin),
        .wrap     (step_wrap)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        gray_d  = gray_q;
        bin_d   = bin_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_RUN: begin
                            state_d = ST_RUN;
                            dir_d   = cmd_dir;
                        end
                        OP_STEP_N: begin
                            state_d = ST_STEP;
                            dir_d   = cmd_dir;
                            rem_d   = cmd_arg;
                        end
                        OP_LOAD: begin
                            gray_d = cmd_arg;
                            bin_d  = gray2bin(cmd_arg);
                        end
                        OP_STOP: ;
                    endcase
                end
            end
            ST_RUN: begin
                adv = 1'b1;
                if (accept) begin
                    case (op)
                        OP_STOP: begin
                            adv     = 1'b0;
                            state_d = ST_IDLE;
                        end
                        OP_LOAD: begin
                            adv    = 1'b0;
                            gray_d = cmd_arg;
                            bin_d  = gray2bin(cmd_arg);
                        end
                        OP_RUN:    dir_d = cmd_dir;
                        OP_STEP_N: err_d = 1'b1;
                    endcase
                end
            end
            ST_STEP: begin
                // A zero-length burst completes one cycle after acceptance without moving.
                if (rem_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    adv   = 1'b1;
                    rem_d = rem_q - WIDTH'(1);
                    if (rem_q == WIDTH'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (adv) begin
            gray_d = step_gray;
            bin_d  = step_bin;
            wrap_d = step_wrap;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            gray_q  <= '0;
            bin_q   <= '0;
            done    <= 1'b0;
            wrap    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            gray_q  <= gray_d;
            bin_q   <= bin_d;
            done    <= done_d;
            wrap    <= wrap_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Bench for gray_seq_ctrl: directed scenarios plus randomized commands
// checked against an integer-count reference model.
module tb_gray_seq_ctrl;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_arg;
    logic         cmd_dir;
    logic [W-1:0] gray_q;
    logic [W-1:0] bin_q;
    logic         busy, done, wrap, err;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: plain integer count plus mode (0 idle, 1 run, 2 burst).
    int m_cnt, m_mode, m_left;
    bit m_dir, m_done, m_wrap, m_err;

    gray_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cmd_dir   (cmd_dir),
        .gray_q    (gray_q),
        .bin_q     (bin_q),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic int to_gray(int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int from_gray(int g);
        for (int b = 0; b <= MAX; b++) begin
            if (to_gray(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_mode = 0; m_left = 0; m_dir = 0;
        m_done = 0; m_wrap = 0; m_err = 0;
    endtask

    task automatic model_advance(bit d);
        if (!d) begin
            m_wrap = (m_cnt == MAX);
            m_cnt  = (m_cnt + 1) % (MAX + 1);
        end else begin
            m_wrap = (m_cnt == 0);
            m_cnt  = (m_cnt + MAX) % (MAX + 1);
        end
    endtask

    task automatic model_edge();
        bit acc;
        if (reset) begin
            model_reset();
            return;
        end
        acc = cmd_valid && (m_mode != 2);
        m_done = 0; m_wrap = 0; m_err = 0;
        if (m_mode == 0) begin
            if (acc && cmd_op == 2'b00) begin m_mode = 1; m_dir = cmd_dir; end
            else if (acc && cmd_op == 2'b10) begin m_mode = 2; m_dir = cmd_dir; m_left = int'(cmd_arg); end
            else if (acc && cmd_op == 2'b11) m_cnt = from_gray(int'(cmd_arg));
        end else if (m_mode == 1) begin
            if (acc && cmd_op == 2'b01) m_mode = 0;
            else if (acc && cmd_op == 2'b11) m_cnt = from_gray(int'(cmd_arg));
            else begin
                if (acc && cmd_op == 2'b00) m_dir = cmd_dir;
                if (acc && cmd_op == 2'b10) m_err = 1;
                model_advance(m_dir);
            end
        end else begin
            if (m_left > 0) begin
                model_advance(m_dir);
                m_left--;
            end
            if (m_left == 0) begin
                m_done = 1;
                m_mode = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(logic [1:0] op, logic [W-1:0] arg, logic d);
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_dir = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = '0; cmd_dir = 1'b0;
        tick(); tick();
        reset = 1'b0;
        vectors++;
        if (gray_q !== 4'b0000 || bin_q !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_state gray=%b bin=%b required 0000/0000", gray_q, bin_q);
        end
        vectors++;
        if ({busy, done, wrap, err, cmd_ready} !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_flags busy/done/wrap/err/ready=%b required 00001",
                     {busy, done, wrap, err, cmd_ready});
        end
    endtask

    task automatic test_load();
        send(2'b11, 4'b0110, 1'b0);
        vectors++;
        if (gray_q !== 4'b0110 || bin_q !== 4'b0100 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL load gray=%b bin=%b busy=%b required 0110/0100/0", gray_q, bin_q, busy);
        end
    endtask

    task automatic test_step3();
        logic [W-1:0] exp_g [3];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0011; exp_g[2] = 4'b0010;
        send(2'b11, 4'b0000, 1'b0);
        send(2'b10, 4'd3, 1'b0);
        vectors++;
        if (cmd_ready !== 1'b0 || gray_q !== 4'b0000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL step3_accept ready=%b gray=%b busy=%b required 0/0000/1", cmd_ready, gray_q, busy);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (gray_q !== exp_g[i] || done !== (i == 2)) begin
                miscompares++;
                $display("FAIL step3_edge%0d gray=%b done=%b required %b/%0d", i + 1, gray_q, done, exp_g[i], i == 2);
            end
        end
        vectors++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL step3_end busy=%b ready=%b required 0/1", busy, cmd_ready);
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL step3_done_width done=%b required 0", done);
        end
    endtask

    task automatic test_run_wrap();
        send(2'b11, 4'b1000, 1'b0);
        send(2'b00, 4'b0000, 1'b0);
        vectors++;
        if (gray_q !== 4'b1000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL run_accept gray=%b busy=%b required 1000/1", gray_q, busy);
        end
        tick();
        vectors++;
        if (gray_q !== 4'b0000 || wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL run_wrap gray=%b wrap=%b required 0000/1", gray_q, wrap);
        end
        tick();
        vectors++;
        if (gray_q !== 4'b0001 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL run_after_wrap gray=%b wrap=%b required 0001/0", gray_q, wrap);
        end
        send(2'b01, 4'b0000, 1'b0);
        tick();
        vectors++;
        if (gray_q !== 4'b0001 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL run_stop gray=%b busy=%b required 0001/0", gray_q, busy);
        end
    endtask

    task automatic test_step_down();
        send(2'b11, 4'b0000, 1'b0);
        send(2'b10, 4'd1, 1'b1);
        tick();
        vectors++;
        if (gray_q !== 4'b1000 || bin_q !== 4'b1111 || wrap !== 1'b1 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL step_down gray=%b bin=%b wrap=%b done=%b required 1000/1111/1/1",
                     gray_q, bin_q, wrap, done);
        end
    endtask

    task automatic test_err_and_n0();
        logic [W-1:0] held;
        send(2'b00, 4'b0000, 1'b0);
        tick();
        send(2'b10, 4'd5, 1'b0);
        vectors++;
        if (err !== 1'b1 || busy !== 1'b1 || gray_q !== W'(to_gray(m_cnt))) begin
            miscompares++;
            $display("FAIL run_err err=%b busy=%b gray=%b required 1/1/%b", err, busy, gray_q, W'(to_gray(m_cnt)));
        end
        tick();
        vectors++;
        if (err !== 1'b0 || gray_q !== W'(to_gray(m_cnt))) begin
            miscompares++;
            $display("FAIL run_err_after err=%b gray=%b required 0/%b", err, gray_q, W'(to_gray(m_cnt)));
        end
        send(2'b01, 4'b0000, 1'b0);
        held = gray_q;
        send(2'b10, 4'd0, 1'b0);
        vectors++;
        if (done !== 1'b0 || cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL n0_t0 done=%b ready=%b required 0/0", done, cmd_ready);
        end
        tick();
        vectors++;
        if (done !== 1'b1 || gray_q !== held || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL n0_done done=%b gray=%b busy=%b required 1/%b/0", done, gray_q, busy, held);
        end
    endtask

    task automatic test_reset_mid_step();
        bit seen_done;
        send(2'b11, 4'b0000, 1'b0);
        send(2'b10, 4'd10, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (gray_q !== 4'b0110) begin
            miscompares++;
            $display("FAIL mid_step gray=%b required 0110", gray_q);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({gray_q, bin_q} !== 8'h00 || {busy, done, wrap, err, cmd_ready} !== 5'b00001) begin
            miscompares++;
            $display("FAIL async_reset gray=%b bin=%b flags=%b required 0000/0000/00001",
                     gray_q, bin_q, {busy, done, wrap, err, cmd_ready});
        end
        tick();
        reset = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || gray_q !== 4'b0000) seen_done = 1;
        end
        vectors++;
        if (seen_done) begin
            miscompares++;
            $display("FAIL reset_discard activity_after_release=1 required 0 (gray=%b)", gray_q);
        end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 9);
            cmd_valid = (r < 6);
            r = $urandom_range(0, 9);
            cmd_op  = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
            cmd_arg = W'($urandom_range(0, MAX));
            cmd_dir = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (cmd_ready !== (m_mode != 2)) begin
                miscompares++;
                $display("FAIL rand_ready cyc=%0d ready=%b required %0d", c, cmd_ready, m_mode != 2);
            end
            tick();
            vectors++;
            if (gray_q !== W'(to_gray(m_cnt)) || bin_q !== W'(m_cnt) || busy !== (m_mode != 0) ||
                done !== m_done || wrap !== m_wrap || err !== m_err) begin
                miscompares++;
                $display("FAIL rand_state cyc=%0d gray=%b bin=%b busy=%b done=%b wrap=%b err=%b required %b/%b/%0d/%0d/%0d/%0d",
                         c, gray_q, bin_q, busy, done, wrap, err, W'(to_gray(m_cnt)), W'(m_cnt),
                         m_mode != 0, m_done, m_wrap, m_err);
            end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load();
        test_step3();
        test_run_wrap();
        test_step_down();
        test_err_and_n0();
        test_reset_mid_step();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gray_seq_ctrl.md
# gray_seq_ctrl

Sequencing controller for the Gray-code counter datapath: owns a WIDTH-bit reflected-Gray state register and advances it under command control (free-run, N-step burst, load, stop) in either direction. Sits between the host/test sequencer and any logic consuming Gray state. Commands arrive over a valid/ready handshake; completion and wrap are reported as single-cycle pulses.

## Interface
- WIDTH, 4, bit width of counter state (≥2)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted this cycle
- cmd_op  in  2  00 RUN, 01 STOP, 10 STEP_N, 11 LOAD
- cmd_arg  in  WIDTH  STEP_N: step count N; LOAD: Gray value; else ignored
- cmd_dir  in  1  0 up, 1 down; sampled on RUN and STEP_N accept
- gray_q  out  WIDTH  current Gray state (registered)
- bin_q  out  WIDTH  binary equivalent of gray_q (registered, always consistent)
- busy  out  1  high in RUN or STEP state
- done  out  1  one-cycle pulse at STEP_N completion
- wrap  out  1  one-cycle pulse on the advance crossing max↔0
- err  out  1  one-cycle pulse on illegal command in current state

## Operation
- Gray code: gray = bin ^ (bin >> 1); up sequence for WIDTH=4: 0000,0001,0011,0010,0110,…,1000,0000.
- States: IDLE, RUN, STEP. Accept = cmd_valid & cmd_ready at a rising edge.
- cmd_ready = 1 in IDLE and RUN, 0 in STEP.
- IDLE: RUN → RUN, latch dir. STEP_N → STEP, latch dir, remaining = N. LOAD → gray_q = cmd_arg, bin_q = decoded value, stay IDLE. STOP → no-op (no err).
- RUN: advance one step every cycle in latched dir. STOP → IDLE, no advance at that edge. LOAD → load value at that edge (replaces advance), stay RUN. RUN → relatch dir, advance in new dir at that edge. STEP_N → rejected, err pulse, advance continues.
- STEP: advance each cycle, decrement remaining; on the last advance: done pulse, → IDLE. Commands not accepted (cmd_ready=0); only reset aborts.
- STEP_N with N=0: no advance, done pulses at edge T0+1, → IDLE.
- wrap: up from all-max binary (Gray 1000 for WIDTH=4) to 0, or down from 0 to max; asserted in the cycle following that edge, coincident with new gray_q.
- Arithmetic: binary counter modulo 2^WIDTH; remaining counter WIDTH bits.

## Timing
- Reset (async assert, sync release): gray_q=0, bin_q=0, state IDLE, busy=0, done=0, wrap=0, err=0, cmd_ready=1.
- Reset mid-RUN or mid-STEP: immediate return to reset values; pending burst discarded, no done.
- Accept edge T0. RUN: first change visible after edge T0+1 (busy high after T0). STEP_N (N≥1): changes at edges T0+1..T0+N; done and busy=0 after edge T0+N; cmd_ready=1 after T0+N, so back-to-back command accepted at T0+N+1.
- LOAD: gray_q reflects cmd_arg after edge T0 (latency 1).
- STOP in RUN at T0: last advance at edge T0−1's successor is suppressed; gray_q holds value from edge T0−1.
- done, wrap, err: registered, exactly one cycle wide; wrap and done may coincide.

## Structure
- Package gray_ctrl_pkg: cmd_op encodings (OP_RUN, OP_STOP, OP_STEP_N, OP_LOAD), state enum (ST_IDLE, ST_RUN, ST_STEP).
- One combinational sub-module gray_step: inputs gray value + dir, outputs next Gray value, next binary value, wrap flag; WIDTH-parameterized.
- Top holds FSM, remaining counter, output registers.

## Test plan
- Reset, LOAD 0110 (WIDTH=4) → after 1 edge gray_q=0110, bin_q=0100, busy=0.
- From 0000, STEP_N N=3 up → gray_q 0001,0011,0010 on edges T0+1..3; done pulse with 0010; cmd_ready low during burst.
- LOAD 1000, RUN up, run 2 cycles → gray_q 0000 with wrap=1, then 0001 wrap=0; STOP → gray_q holds.
- From 0000, STEP_N N=1 down → gray_q 1000, wrap=1, done=1 same cycle.
- In RUN issue STEP_N → err pulse, counting uninterrupted; STEP_N N=0 in IDLE → done at T0+1, gray_q unchanged.
- Assert reset mid-STEP (N=10, after 4 steps) → all outputs to reset values immediately, no done after release.
